// File: rtl/uart_tx.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1/2 stops; 16 tx_clk per bit, tx registered.
// Latency: tx falls on the edge that accepts tx_start; no backpressure, tx_start is ignored while busy. Optional UART_TX_BREAK_EN.
module uart_tx (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [3:0] length,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop2,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx,
  output logic       tx_done,
  output logic       tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] last_bit;
    logic       par_bit;
    logic       par_en;
    logic       stop2;
  } frame_t;

  state_t     state_q, state_nxt;
  frame_t     frame_q, frame_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic [2:0] bit_cnt_q, bit_cnt_nxt;
  logic       tx_nxt, done_nxt;
  logic       brk_req;
  logic       bit_end;
  logic       start_ok;
  logic [2:0] len_last;
  logic [7:0] len_mask;

`ifdef UART_TX_BREAK_EN
  assign brk_req = tx_break;
`else
  assign brk_req = 1'b0;
`endif

  assign bit_end  = (cnt_q == 4'd15);
  assign start_ok = tx_start & ~brk_req;
  assign tx_busy  = (state_q != S_IDLE);

  // Out-of-range lengths fall back to 8 bits; parity covers only the bits actually sent.
  always_comb begin
    len_last = 3'd7;
    if (length >= 4'd5 && length <= 4'd8)
      len_last = 3'(length - 4'd1);
    for (int i = 0; i < 8; i++)
      len_mask[i] = (3'(i) <= len_last);
  end

  always_comb begin
    frame_nxt          = frame_q;
    frame_nxt.data     = tx_data;
    frame_nxt.last_bit = len_last;
    frame_nxt.par_bit  = (^(tx_data & len_mask)) ^ ~parity_type;
    frame_nxt.par_en   = parity_en;
    frame_nxt.stop2    = stop2;
  end

  // State, counters and registered outputs.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      cnt_q     <= 4'd0;
      bit_cnt_q <= 3'd0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      tx        <= tx_nxt;
      tx_done   <= done_nxt;
      if (state_q == S_IDLE && start_ok)
        frame_q <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:
        if (bit_end && bit_cnt_q == frame_q.last_bit)
          state_nxt = frame_q.par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (bit_end) state_nxt = S_STOP1;
      S_STOP1:  if (bit_end) state_nxt = frame_q.stop2 ? S_STOP2 : S_DONE;
      S_STOP2:  if (bit_end) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Cycle counter wraps naturally at 15; it only runs inside the bit-timed states.
  always_comb begin
    cnt_nxt     = 4'd0;
    bit_cnt_nxt = 3'd0;
    case (state_q)
      S_START, S_PARITY, S_STOP1, S_STOP2: cnt_nxt = cnt_q + 4'd1;
      S_DATA: begin
        cnt_nxt     = cnt_q + 4'd1;
        bit_cnt_nxt = bit_cnt_q;
        if (bit_end)
          bit_cnt_nxt = (bit_cnt_q == frame_q.last_bit) ? 3'd0 : bit_cnt_q + 3'd1;
      end
      default: begin
        cnt_nxt     = 4'd0;
        bit_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Line level is decoded from the next state so tx lands in a flop with the state.
  always_comb begin
    tx_nxt   = 1'b1;
    done_nxt = 1'b0;
    case (state_nxt)
      S_IDLE:   tx_nxt = ~(brk_req && state_q == S_IDLE);
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = frame_q.data[bit_cnt_nxt];
      S_PARITY: tx_nxt = frame_q.par_bit;
      S_DONE: begin
        tx_nxt   = 1'b1;
        done_nxt = 1'b1;
      end
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, timing of tx_done/tx_busy, ignored starts, reset and break.
module tb_uart_tx;
  logic       tx_clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] length;
  logic       parity_type;
  logic       parity_en;
  logic       stop2;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif
  logic       tx;
  logic       tx_done;
  logic       tx_busy;

  int tests = 0;
  int fails = 0;

  uart_tx dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .length      (length),
    .parity_type (parity_type),
    .parity_en   (parity_en),
    .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
    .tx_break    (tx_break),
`endif
    .tx          (tx),
    .tx_done     (tx_done),
    .tx_busy     (tx_busy)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    @(negedge tx_clk);
  endtask

  // mode 0: plain frame; 1: perturb inputs and tx_start mid-frame; 2: hold tx_start high throughout.
  // exp_bits[j] is the expected line level in bit period j (j=0 is the start bit); k counts edges from E0.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] len, input logic pen,
                           input logic ptype, input logic s2, input logic [15:0] exp_bits,
                           input int n, input string tag, input int mode);
    int done_at, fall_at, done_cnt;
    done_at = -1; fall_at = -1; done_cnt = 0;
    tx_data = d; length = len; parity_en = pen; parity_type = ptype; stop2 = s2;
    tx_start = 1'b1;
    for (int k = 0; k <= 16*n + 1; k++) begin
      tick();
      if (mode != 2) tx_start = 1'b0;
      if (mode == 1) begin
        if (k == 30 || k == 31 || k == 60) tx_start = 1'b1;
        if (k == 40) begin
          tx_data = 8'h00; length = 4'd5; parity_en = 1'b0; stop2 = 1'b1;
        end
        if (k == 16*n) tx_start = 1'b1;
      end
      if (k % 16 == 8)
        check($sformatf("%s bit%0d", tag, k/16), int'(tx), int'(exp_bits[k/16]));
      if (tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (!tx_busy && fall_at < 0) fall_at = k;
    end
    check({tag, " done_at"}, done_at, 16*n);
    check({tag, " busy_fall"}, fall_at, 16*n + 1);
    check({tag, " done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; length = 4'd8;
    parity_type = 1'b0; parity_en = 1'b0; stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b0;
`endif
    tick(); tick();
    check("reset tx", int'(tx), 1);
    check("reset done", int'(tx_done), 0);
    check("reset busy", int'(tx_busy), 0);
    rst = 1'b0;
    tick();

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    run_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 16'h02AA, 10, "8n1", 0);
    tick();
    // 0xA3 len5 even: 0,1,1,0,0,0,par=0,1
    run_frame(8'hA3, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0086, 8, "5e1", 0);
    tick();
    // same, odd parity: parity bit 1
    run_frame(8'hA3, 4'd5, 1'b1, 1'b0, 1'b0, 16'h00C6, 8, "5o1", 0);
    tick();
    // length 12 -> 8 bits, two stop bits
    run_frame(8'hFF, 4'd12, 1'b0, 1'b0, 1'b1, 16'h07FE, 11, "8n2", 0);
    tick();

    // 0x3C 8E1 with mid-frame input changes and ignored starts (including during DONE)
    run_frame(8'h3C, 4'd8, 1'b1, 1'b1, 1'b0, 16'h0478, 11, "ign", 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_busy) cnt++;
    end
    check("ign no_second_frame", cnt, 0);

    // tx_start held high: exactly one idle cycle, then the next frame starts
    run_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 16'h02AA, 10, "hold", 2);
    tick();
    check("hold restart busy", int'(tx_busy), 1);
    check("hold restart tx", int'(tx), 0);
    tx_start = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 161; i++) begin
      tick();
      if (tx_done) cnt++;
    end
    check("hold frame2 done_cnt", cnt, 1);
    check("hold frame2 idle", int'(tx_busy), 0);
    tick();

    // reset at E0+50
    tx_data = 8'h00; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    tx_start = 1'b1;
    cnt = 0;
    for (int k = 0; k <= 50; k++) begin
      tick();
      tx_start = 1'b0;
      if (tx_done) cnt++;
    end
    rst = 1'b1;
    tick();
    check("rst tx", int'(tx), 1);
    check("rst busy", int'(tx_busy), 0);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_done || tx_busy) cnt++;
    end
    check("rst no_done", cnt, 0);
    run_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 16'h02AA, 10, "post_rst", 0);
    tick();

`ifdef UART_TX_BREAK_EN
    tx_break = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tx_start = k[0];
      tick();
      if (tx !== 1'b0 || tx_busy !== 1'b0) cnt++;
    end
    check("break held_low", cnt, 0);
    tx_break = 1'b0;
    tx_start = 1'b0;
    tick();
    check("break release tx", int'(tx), 1);
    check("break release busy", int'(tx_busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
